alu_seq: RTL and testbench

- Multi-cycle successor to the combinational 8-op ALU, parametrised in `DATA_WIDTH`.
- Adds a valid/ready handshake on input and output, registered results and status flags.
- Uses iterative shift-add multiply and restoring divide, so no wide combinational `*` or `/`.
- Sits between the datapath register file and the accumulator/writeback stage.

---
 rtl/alu_seq.sv | 180 ++++++++++++++++++
 tb/tb_alu_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle 8-op ALU with valid/ready handshake and shift-add mul / restoring div
// Optional feature macro: ALU_SEQ_REMAINDER_EN (drives r with the division remainder)
module alu_seq #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            oc,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] f,
    output logic [DATA_WIDTH-1:0] r,
    output logic [4:0]            flags
);

    localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] OC_ADD = 3'b000;
    localparam logic [2:0] OC_SUB = 3'b001;
    localparam logic [2:0] OC_MUL = 3'b010;
    localparam logic [2:0] OC_DIV = 3'b011;
    localparam logic [2:0] OC_NOT = 3'b100;
    localparam logic [2:0] OC_XOR = 3'b101;
    localparam logic [2:0] OC_OR  = 3'b110;
    localparam logic [2:0] OC_AND = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t                  state;
    logic [CW-1:0]           count;
    logic                    op_mul;
    logic [DATA_WIDTH-1:0]   opa;
    logic [DATA_WIDTH-1:0]   opb;
    // hi: upper product half (mul) or partial remainder (div)
    // lo: multiplier being shifted out (mul) or dividend/quotient (div)
    logic [DATA_WIDTH-1:0]   hi;
    logic [DATA_WIDTH-1:0]   lo;
    logic [DATA_WIDTH-1:0]   f_q;
    logic [4:0]              flags_q;

    logic [DATA_WIDTH:0]     add_sum;
    logic [DATA_WIDTH-1:0]   sc_f;
    logic                    sc_cy;
    logic                    starts_iter;

    logic [DATA_WIDTH:0]     mul_sum;
    logic [DATA_WIDTH:0]     div_sh;
    logic                    div_ge;
    logic [DATA_WIDTH-1:0]   div_diff;
    logic [DATA_WIDTH-1:0]   hi_n;
    logic [DATA_WIDTH-1:0]   lo_n;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign f         = f_q;
    assign flags     = flags_q;

    // Single-cycle results straight from the presented operands (only used on the accept edge)
    always_comb begin
        add_sum     = {1'b0, a} + {1'b0, b};
        sc_f        = '0;
        sc_cy       = 1'b0;
        starts_iter = (oc == OC_MUL) || ((oc == OC_DIV) && (b != '0));
        case (oc)
            OC_ADD: begin
                sc_f  = add_sum[DATA_WIDTH-1:0];
                sc_cy = add_sum[DATA_WIDTH];
            end
            OC_SUB: begin
                sc_f  = a - b;
                sc_cy = (a < b);
            end
            OC_DIV:  sc_f = '1;
            OC_NOT:  sc_f = ~a;
            OC_XOR:  sc_f = a ^ b;
            OC_OR:   sc_f = a | b;
            OC_AND:  sc_f = a & b;
            default: sc_f = '0;
        endcase
    end

    // One shift-add (mul) or restoring-subtract (div) step on the hi/lo pair
    always_comb begin
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
        div_sh   = {hi, lo[DATA_WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, opb});
        div_diff = div_sh[DATA_WIDTH-1:0] - opb;
        if (op_mul) begin
            hi_n = mul_sum[DATA_WIDTH:1];
            lo_n = {mul_sum[0], lo[DATA_WIDTH-1:1]};
        end else begin
            hi_n = div_ge ? div_diff : div_sh[DATA_WIDTH-1:0];
            lo_n = {lo[DATA_WIDTH-2:0], div_ge};
        end
    end

`ifdef ALU_SEQ_REMAINDER_EN
    logic [DATA_WIDTH-1:0] r_q;

    // Remainder output register: a on div-by-zero, final partial remainder on div, else 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (state == IDLE && in_valid && !starts_iter) begin
            r_q <= (oc == OC_DIV) ? a : '0;
        end else if (state == BUSY && count == LAST_ITER) begin
            r_q <= op_mul ? '0 : hi_n;
        end
    end

    assign r = r_q;
`else
    assign r = '0;
`endif

    // Control FSM with registered result and flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= '0;
            op_mul  <= 1'b0;
            opa     <= '0;
            opb     <= '0;
            hi      <= '0;
            lo      <= '0;
            f_q     <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (starts_iter) begin
                            state  <= BUSY;
                            count  <= '0;
                            op_mul <= (oc == OC_MUL);
                            opa    <= a;
                            opb    <= b;
                            hi     <= '0;
                            lo     <= (oc == OC_MUL) ? b : a;
                        end else begin
                            state   <= DONE;
                            f_q     <= sc_f;
                            flags_q <= {(oc == OC_DIV), 1'b0, sc_cy,
                                        sc_f[DATA_WIDTH-1], (sc_f == '0)};
                        end
                    end
                end
                BUSY: begin
                    hi <= hi_n;
                    lo <= lo_n;
                    if (count == LAST_ITER) begin
                        state   <= DONE;
                        count   <= '0;
                        f_q     <= lo_n;
                        flags_q <= {1'b0, op_mul & (hi_n != '0), 1'b0,
                                    lo_n[DATA_WIDTH-1], (lo_n == '0)};
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (table vectors, corner sequences, random vs model)
module tb_alu_seq;

`ifdef ALU_SEQ_REMAINDER_EN
    localparam bit REM_EN = 1'b1;
`else
    localparam bit REM_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  oc;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] f;
    logic [15:0] r;
    logic [4:0]  flags;

    int vectors;
    int miscompares;

    alu_seq #(.DATA_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .oc        (oc),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .r         (r),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  oc;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] f;
        logic [15:0] r_rem;
        logic [4:0]  flags;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one op, accept it, scramble inputs, then wait for out_valid
    task automatic do_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         output int lat);
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        oc       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        oc       = 3'($urandom);
        a        = 16'($urandom);
        b        = 16'($urandom);
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        chk("in_ready_in_done", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("out_valid_drop", 32'(out_valid), 32'd0);
        chk("in_ready_return", 32'(in_ready), 32'd1);
    endtask

    task automatic check_result(input logic [15:0] ef, input logic [15:0] er,
                                input logic [4:0] efl, input int el, input int lat);
        chk("latency", 32'(lat), 32'(el));
        chk("f", 32'(f), 32'(ef));
        chk("r", 32'(r), 32'(er));
        chk("flags", 32'(flags), 32'(efl));
    endtask

    // Reference model in plain integer arithmetic
    function automatic void model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] ef, output logic [15:0] er,
                                  output logic [4:0] efl, output int el);
        longint unsigned ua = 64'(x);
        longint unsigned ub = 64'(y);
        longint unsigned res = 0;
        bit cy = 0;
        bit ovf = 0;
        bit dz = 0;
        er = 16'h0;
        el = 1;
        case (o)
            3'd0: begin res = ua + ub; cy = (res > 65535); end
            3'd1: begin res = (ua >= ub) ? ua - ub : ua + 65536 - ub; cy = (ua < ub); end
            3'd2: begin res = ua * ub; ovf = (res > 65535); el = 17; end
            3'd3: begin
                if (ub == 0) begin
                    res = 65535; er = x; dz = 1;
                end else begin
                    res = ua / ub; er = 16'(ua % ub); el = 17;
                end
            end
            3'd4: res = 65535 - ua;
            3'd5: res = ua ^ ub;
            3'd6: res = ua | ub;
            default: res = ua & ub;
        endcase
        ef = 16'(res % 65536);
        if (!REM_EN || o != 3'd3) er = 16'h0;
        efl = {dz, ovf, cy, ef[15], (ef == 16'h0)};
    endfunction

    initial begin
        int lat;
        logic [15:0] ef, er, hold_f;
        logic [4:0]  efl, hold_fl;
        int el;
        logic [2:0]  ro;
        logic [15:0] ra, rb;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        oc          = 3'b000;
        a           = 16'h0;
        b           = 16'h0;

        tbl[0]  = '{3'b000, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 5'b00000, 1};
        tbl[1]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 5'b00101, 1};
        tbl[2]  = '{3'b001, 16'h0002, 16'h0005, 16'hFFFD, 16'h0000, 5'b00110, 1};
        tbl[3]  = '{3'b010, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 5'b01001, 17};
        tbl[4]  = '{3'b010, 16'd12,   16'd13,   16'd156,  16'h0000, 5'b00000, 17};
        tbl[5]  = '{3'b011, 16'd100,  16'd7,    16'd14,   16'd2,    5'b00000, 17};
        tbl[6]  = '{3'b011, 16'd5,    16'd0,    16'hFFFF, 16'd5,    5'b10010, 1};
        tbl[7]  = '{3'b100, 16'h00FF, 16'h1234, 16'hFF00, 16'h0000, 5'b00010, 1};
        tbl[8]  = '{3'b101, 16'hA5A5, 16'hA5A5, 16'h0000, 16'h0000, 5'b00001, 1};
        tbl[9]  = '{3'b110, 16'h1200, 16'h0034, 16'h1234, 16'h0000, 5'b00000, 1};
        tbl[10] = '{3'b111, 16'hF0F0, 16'h0FF0, 16'h00F0, 16'h0000, 5'b00000, 1};
        tbl[11] = '{3'b011, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 5'b00010, 17};
        tbl[12] = '{3'b010, 16'hFFFF, 16'hFFFF, 16'h0001, 16'h0000, 5'b01000, 17};

        // Reset state
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_f", 32'(f), 32'd0);
        chk("rst_r", 32'(r), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed table
        for (int i = 0; i < 13; i++) begin
            do_op(tbl[i].oc, tbl[i].a, tbl[i].b, lat);
            check_result(tbl[i].f, REM_EN ? tbl[i].r_rem : 16'h0, tbl[i].flags, tbl[i].lat, lat);
            release_result();
        end

        // Backpressure: result held, competing in_valid ignored
        do_op(3'b000, 16'h0003, 16'h0004, lat);
        check_result(16'h0007, 16'h0, 5'b00000, 1, lat);
        hold_f   = f;
        hold_fl  = flags;
        oc       = 3'b010;
        a        = 16'h00FF;
        b        = 16'h0003;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_f_stable", 32'(f), 32'(hold_f));
            chk("bp_flags_stable", 32'(flags), 32'(hold_fl));
        end
        in_valid = 1'b0;
        release_result();

        // Reset in the middle of a multiply
        do_op(3'b000, 16'h1111, 16'h2222, lat);
        release_result();
        oc       = 3'b010;
        a        = 16'd12;
        b        = 16'd13;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_busy_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_f", 32'(f), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_hold_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(3'b010, 16'd12, 16'd13, lat);
        check_result(16'd156, 16'h0, 5'b00000, 17, lat);
        release_result();

        // Randomized ops against the reference model
        for (int i = 0; i < 200; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 5) == 0) rb = 16'($urandom_range(1, 15));
            model(ro, ra, rb, ef, er, efl, el);
            do_op(ro, ra, rb, lat);
            check_result(ef, er, efl, el, lat);
            release_result();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
